// File: rtl/dtu_cred_sched.sv
// ============================================================================
// dtu_cred_sched
// ----------------------------------------------------------------------------
// Credit-gated round-robin scheduler. N_ID vFPGA regions compete for a single
// bypass request channel (bpss rd or wr). Each region may have at most N_CRED
// requests outstanding. A credit is taken when a request is accepted from the
// region and handed back by a per-request completion pulse.
//
// Build option:
//   DTU_SCHED_STATS_EN  when defined, adds a per-region counter of downstream
//                       handshakes, readable through stat_sel / stat_issued.
//
// Ports:
//   aclk, areset     clock; asynchronous active-high reset
//   s_req_valid      per-region request valid                     [N_ID]
//   s_req_ready      per-region ready, at most one bit high       [N_ID]
//   s_req_data       per-region request descriptor                [N_ID][REQ_W]
//   m_req_valid      scheduled request valid
//   m_req_ready      downstream ready
//   m_req_data       scheduled descriptor                         [REQ_W]
//   m_req_id         region index of m_req_data                   [ID_BITS]
//   cpl_valid        completion pulse, one per issued request
//   cpl_id           region index of the completion               [ID_BITS]
//   cred_out         outstanding count per region                 [N_ID][CRED_BITS]
//   cpl_err          sticky: completion with nothing outstanding, or bad id
//   stat_sel         (stats build) region whose count is read     [ID_BITS]
//   stat_issued      (stats build) handshakes issued for stat_sel [32]
//
// Timing: a request accepted in cycle N appears on m_req_* in cycle N+1 and is
// held until m_req_ready. The scheduler accepts at most one request every
// other cycle.
// ============================================================================
module dtu_cred_sched #(
    parameter int N_ID      = 4,
    parameter int N_CRED    = 8,
    parameter int REQ_W     = 64,
    parameter int ID_BITS   = (N_ID > 1) ? $clog2(N_ID) : 1,
    parameter int CRED_BITS = $clog2(N_CRED + 1)
) (
    input  logic                            aclk,
    input  logic                            areset,

    input  logic [N_ID-1:0]                 s_req_valid,
    output logic [N_ID-1:0]                 s_req_ready,
    input  logic [N_ID-1:0][REQ_W-1:0]      s_req_data,

    output logic                            m_req_valid,
    input  logic                            m_req_ready,
    output logic [REQ_W-1:0]                m_req_data,
    output logic [ID_BITS-1:0]              m_req_id,

    input  logic                            cpl_valid,
    input  logic [ID_BITS-1:0]              cpl_id,

    output logic [N_ID-1:0][CRED_BITS-1:0]  cred_out,
    output logic                            cpl_err
`ifdef DTU_SCHED_STATS_EN
    ,
    input  logic [ID_BITS-1:0]              stat_sel,
    output logic [31:0]                     stat_issued
`endif
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t                         r_state;
    logic [ID_BITS-1:0]             r_rr_ptr;
    logic [REQ_W-1:0]               r_data;
    logic [ID_BITS-1:0]             r_id;
    logic [N_ID-1:0][CRED_BITS-1:0] r_cnt;
    logic                           r_cpl_err;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    state_t                         w_state_nxt;
    logic [N_ID-1:0]                w_elig;
    logic                           w_any;
    logic [ID_BITS-1:0]             w_grant;
    logic [ID_BITS-1:0]             w_scan;
    logic [N_ID-1:0]                w_ready;
    logic                           w_take;
    logic [N_ID-1:0]                w_inc;
    logic [N_ID-1:0]                w_dec;
    logic                           w_cpl_bad;
    logic                           w_m_fire;

    // Next index around the ring; handles N_ID that is not a power of two.
    function automatic logic [ID_BITS-1:0] f_next_idx(input logic [ID_BITS-1:0] idx);
        if (int'(idx) >= N_ID - 1) begin
            return '0;
        end
        return idx + ID_BITS'(1);
    endfunction

    // ------------------------------------------------------------------
    // Eligibility: requesting and below the credit ceiling
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < N_ID; i++) begin
            w_elig[i] = s_req_valid[i] && (r_cnt[i] < CRED_BITS'(N_CRED));
        end
    end

    // ------------------------------------------------------------------
    // Round-robin pick: first eligible region starting at r_rr_ptr
    // ------------------------------------------------------------------
    // NOTE: every signal driven here gets a default before the loop, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_any   = 1'b0;
        w_grant = '0;
        w_scan  = r_rr_ptr;
        for (int k = 0; k < N_ID; k++) begin
            if (!w_any && w_elig[w_scan]) begin
                w_any   = 1'b1;
                w_grant = w_scan;
            end
            w_scan = f_next_idx(w_scan);
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = '0;
        w_take      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_take           = 1'b1;
                    w_ready[w_grant] = 1'b1;
                    w_state_nxt      = ST_SEND;
                end
            end
            ST_SEND: begin
                if (m_req_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // s_req_ready is combinational off live requests, so it is forced low
    // while reset is held to keep upstream from seeing a phantom accept.
    assign s_req_ready = areset ? '0 : w_ready;

    assign m_req_valid = (r_state == ST_SEND);
    assign m_req_data  = r_data;
    assign m_req_id    = r_id;
    assign w_m_fire    = m_req_valid && m_req_ready;

    // NOTE: state, pointer and data registers use non-blocking assignments so
    // every flop samples the pre-edge values regardless of block ordering.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= '0;
            r_data   <= '0;
            r_id     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_take) begin
                r_data   <= s_req_data[w_grant];
                r_id     <= w_grant;
                r_rr_ptr <= f_next_idx(w_grant);
            end
        end
    end

    // ------------------------------------------------------------------
    // Credit accounting
    // ------------------------------------------------------------------
    // A completion only decrements a counter that is currently non-zero; any
    // completion that finds no matching outstanding request (zero count or an
    // id outside 0..N_ID-1) raises the sticky error instead.
    always_comb begin
        for (int i = 0; i < N_ID; i++) begin
            w_inc[i] = w_take && (w_grant == ID_BITS'(i));
            w_dec[i] = cpl_valid && (cpl_id == ID_BITS'(i)) && (r_cnt[i] != '0);
        end
        w_cpl_bad = cpl_valid && !(|w_dec);
    end

    // NOTE: the counter array is small and architecturally visible on
    // cred_out, so every entry is reset rather than left as uninitialised
    // storage.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_cnt     <= '0;
            r_cpl_err <= 1'b0;
        end else begin
            for (int i = 0; i < N_ID; i++) begin
                // Consume and completion on the same region cancel out.
                if (w_inc[i] && !w_dec[i]) begin
                    r_cnt[i] <= r_cnt[i] + CRED_BITS'(1);
                end else if (w_dec[i] && !w_inc[i]) begin
                    r_cnt[i] <= r_cnt[i] - CRED_BITS'(1);
                end
            end
            if (w_cpl_bad) begin
                r_cpl_err <= 1'b1;
            end
        end
    end

    assign cred_out = r_cnt;
    assign cpl_err  = r_cpl_err;

`ifdef DTU_SCHED_STATS_EN
    // ------------------------------------------------------------------
    // Per-region issue statistics (downstream handshakes)
    // ------------------------------------------------------------------
    logic [31:0] r_issued [N_ID];
    logic [31:0] r_stat_q;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < N_ID; i++) begin
                r_issued[i] <= '0;
            end
            r_stat_q <= '0;
        end else begin
            if (w_m_fire) begin
                // Free-running; wraps 2^32-1 -> 0 by natural overflow.
                r_issued[r_id] <= r_issued[r_id] + 32'd1;
            end
            if (int'(stat_sel) < N_ID) begin
                r_stat_q <= r_issued[stat_sel];
            end else begin
                r_stat_q <= '0;
            end
        end
    end

    assign stat_issued = r_stat_q;
`endif

endmodule

// File: tb/tb_dtu_cred_sched.sv
// Bench for dtu_cred_sched with N_ID=4, N_CRED=2.
// A reference model predicts, every cycle, which region is granted and how
// the credit counters and error flag evolve; predicted descriptors go into a
// queue that an independent monitor pops on every downstream handshake.
module tb_dtu_cred_sched;

    localparam int N_ID      = 4;
    localparam int N_CRED    = 2;
    localparam int REQ_W     = 16;
    localparam int ID_BITS   = 2;
    localparam int CRED_BITS = 2;

    logic                            aclk;
    logic                            areset;
    logic [N_ID-1:0]                 s_req_valid;
    logic [N_ID-1:0]                 s_req_ready;
    logic [N_ID-1:0][REQ_W-1:0]      s_req_data;
    logic                            m_req_valid;
    logic                            m_req_ready;
    logic [REQ_W-1:0]                m_req_data;
    logic [ID_BITS-1:0]              m_req_id;
    logic                            cpl_valid;
    logic [ID_BITS-1:0]              cpl_id;
    logic [N_ID-1:0][CRED_BITS-1:0]  cred_out;
    logic                            cpl_err;

    dtu_cred_sched #(
        .N_ID   (N_ID),
        .N_CRED (N_CRED),
        .REQ_W  (REQ_W)
    ) dut (
        .aclk        (aclk),
        .areset      (areset),
        .s_req_valid (s_req_valid),
        .s_req_ready (s_req_ready),
        .s_req_data  (s_req_data),
        .m_req_valid (m_req_valid),
        .m_req_ready (m_req_ready),
        .m_req_data  (m_req_data),
        .m_req_id    (m_req_id),
        .cpl_valid   (cpl_valid),
        .cpl_id      (cpl_id),
        .cred_out    (cred_out),
        .cpl_err     (cpl_err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model (plain integers, one step per clock)
    // ------------------------------------------------------------------
    typedef struct {
        logic [REQ_W-1:0] data;
        int               id;
    } exp_t;

    exp_t exp_q[$];
    int   m_cnt [N_ID];
    int   m_ptr;
    bit   m_busy;
    bit   m_err;
    int   m_g;
    logic [N_ID-1:0]                m_exp_rdy;
    logic [N_ID-1:0][CRED_BITS-1:0] m_exp_cred;

    always @(negedge aclk) begin
        if (areset) begin
            check("rst_m_valid", m_req_valid, 0);
            check("rst_s_ready", s_req_ready, 0);
            check("rst_cred", cred_out, 0);
            check("rst_cpl_err", cpl_err, 0);
            for (int i = 0; i < N_ID; i++) m_cnt[i] = 0;
            m_ptr  = 0;
            m_busy = 0;
            m_err  = 0;
            exp_q.delete();
        end else begin
            // Compare present outputs with the model's present state.
            check("m_valid", m_req_valid, m_busy);
            for (int i = 0; i < N_ID; i++) m_exp_cred[i] = CRED_BITS'(m_cnt[i]);
            check("cred_out", cred_out, m_exp_cred);
            check("cpl_err", cpl_err, m_err);

            m_g = -1;
            if (!m_busy) begin
                for (int k = 0; k < N_ID; k++) begin
                    int idx;
                    idx = (m_ptr + k) % N_ID;
                    if (m_g < 0 && s_req_valid[idx] && m_cnt[idx] < N_CRED) m_g = idx;
                end
            end
            m_exp_rdy = '0;
            if (m_g >= 0) m_exp_rdy[m_g] = 1'b1;
            check("s_ready", s_req_ready, m_exp_rdy);

            // Advance the model across the coming clock edge.
            if (cpl_valid) begin
                if (int'(cpl_id) < N_ID && m_cnt[cpl_id] > 0) m_cnt[cpl_id]--;
                else m_err = 1;
            end
            if (m_g >= 0) begin
                exp_t e;
                e.data = s_req_data[m_g];
                e.id   = m_g;
                exp_q.push_back(e);
                m_cnt[m_g]++;
                m_ptr  = (m_g + 1) % N_ID;
                m_busy = 1;
            end else if (m_busy && m_req_ready) begin
                m_busy = 0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor: pops the scoreboard on every downstream handshake
    // ------------------------------------------------------------------
    int hs_count = 0;
    int hist[$];

    always @(negedge aclk) begin
        if (!areset && m_req_valid && m_req_ready) begin
            hs_count++;
            hist.push_back(int'(m_req_id));
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_unexpected actual_id=%0d expected=none at %0t", m_req_id, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_id", m_req_id, e.id);
                check("sb_data", m_req_data, e.data);
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver helpers
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // Return a completion for some region the model shows outstanding.
    task automatic auto_cpl(input bit rnd);
        int cand[$];
        for (int i = 0; i < N_ID; i++) if (m_cnt[i] > 0) cand.push_back(i);
        if (cand.size() > 0 && (!rnd || $urandom_range(0, 1) == 1)) begin
            cpl_valid = 1'b1;
            cpl_id    = ID_BITS'(rnd ? cand[$urandom_range(0, cand.size() - 1)] : cand[0]);
        end else begin
            cpl_valid = 1'b0;
        end
    endtask

    task automatic drain();
        s_req_valid = '0;
        m_req_ready = 1'b1;
        repeat (N_ID * N_CRED + 4) begin
            auto_cpl(1'b0);
            step();
        end
        cpl_valid = 1'b0;
        step();
    endtask

    int h0;

    initial begin
        areset      = 1'b1;
        s_req_valid = '0;
        s_req_data  = '0;
        m_req_ready = 1'b0;
        cpl_valid   = 1'b0;
        cpl_id      = '0;
        repeat (3) step();
        areset = 1'b0;

        // All regions requesting, downstream always ready, immediate credits.
        hist.delete();
        h0          = hs_count;
        s_req_valid = 4'hf;
        m_req_ready = 1'b1;
        repeat (20) begin
            for (int i = 0; i < N_ID; i++) s_req_data[i] = REQ_W'($urandom);
            auto_cpl(1'b0);
            step();
        end
        check("rr_issue_rate", hs_count - h0, 10);
        for (int i = 0; i < 8; i++) begin
            if (i < hist.size()) check("rr_order", hist[i], i % N_ID);
            else check("rr_order_missing", hist.size(), 8);
        end
        drain();

        // Credit ceiling: region 1 alone, no completions.
        h0          = hs_count;
        s_req_valid = 4'b0010;
        s_req_data[1] = 16'h1111;
        repeat (12) step();
        check("cred_limit_issued", hs_count - h0, 2);
        check("cred_limit_ready", s_req_ready[1], 0);
        check("cred_limit_cnt", cred_out[1], 2);
        cpl_valid = 1'b1;
        cpl_id    = 2'd1;
        step();
        cpl_valid = 1'b0;
        check("cred_regrant_ready", s_req_ready[1], 1);
        step();
        check("cred_regrant_valid", m_req_valid, 1);
        repeat (3) step();
        check("cred_third_issued", hs_count - h0, 3);
        drain();

        // Downstream stall while SEND is holding region 0's descriptor.
        s_req_valid   = 4'b0001;
        s_req_data[0] = 16'ha5c3;
        m_req_ready   = 1'b0;
        step();
        repeat (10) begin
            s_req_data[0] = REQ_W'($urandom);
            s_req_valid   = 4'($urandom);
            step();
            check("stall_valid", m_req_valid, 1);
            check("stall_id", m_req_id, 0);
            check("stall_data", m_req_data, 16'ha5c3);
            check("stall_no_ready", s_req_ready, 0);
            check("stall_cred", cred_out[0], 1);
        end
        drain();

        // Region 2 consumes and completes in the same cycle.
        s_req_valid = 4'b0100;
        step();
        step();
        cpl_valid = 1'b1;
        cpl_id    = 2'd2;
        step();
        cpl_valid   = 1'b0;
        s_req_valid = '0;
        check("same_cycle_cnt", cred_out[2], 1);
        drain();

        // Completion for a region with nothing outstanding.
        cpl_valid = 1'b1;
        cpl_id    = 2'd3;
        step();
        cpl_valid = 1'b0;
        check("err_set", cpl_err, 1);
        check("err_cred_unchanged", cred_out, 0);
        step();
        check("err_sticky", cpl_err, 1);
        areset = 1'b1;
        #1;
        check("err_cleared", cpl_err, 0);
        step();
        areset = 1'b0;

        // Reset in the middle of SEND with the pointer moved past region 2.
        s_req_valid = 4'b0100;
        m_req_ready = 1'b0;
        step();
        check("pre_rst_valid", m_req_valid, 1);
        s_req_valid = 4'b1010;
        areset      = 1'b1;
        #1;
        check("rst_drop_valid", m_req_valid, 0);
        check("rst_drop_cred", cred_out, 0);
        step();
        step();
        areset      = 1'b0;
        m_req_ready = 1'b1;
        hist.delete();
        repeat (4) step();
        if (hist.size() > 0) check("post_rst_grant", hist[0], 1);
        else check("post_rst_grant_missing", hist.size(), 1);
        drain();

        // Randomised traffic.
        repeat (1500) begin
            s_req_valid = 4'($urandom);
            for (int i = 0; i < N_ID; i++) s_req_data[i] = REQ_W'($urandom);
            m_req_ready = ($urandom_range(0, 3) != 0);
            auto_cpl(1'b1);
            step();
        end
        drain();
        check("sb_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
